// File: rtl/sonic_irq_doorbell.sv
// Host doorbell receiver for the RX interrupt path: tracks ring occupancy from the
// host read pointer and DMA write pointer, and raises moderated one-at-a-time IRQs.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// DISARMED  | host has not armed interrupts; no request issued
// ARMED     | waiting for ring occupancy to reach the threshold
// REQ       | irq_req held high until the generator acks
// HOLDOFF   | post-ack moderation gap, counting down before re-arming
module sonic_irq_doorbell #(
  parameter int USED_QWORDS_WIDTH = 16,
  parameter int HOLDOFF_WIDTH     = 16,
  parameter int DEF_HOLDOFF       = 256,
  parameter int DEF_THRESH        = 1
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         db_wrena,
  input  logic [7:0]                   db_addr,
  input  logic [31:0]                  db_wrdata,
  output logic [31:0]                  db_rddata,
  input  logic [USED_QWORDS_WIDTH-1:0] rx_ring_wptr,
  output logic [USED_QWORDS_WIDTH-1:0] rx_ring_rptr,
  output logic [USED_QWORDS_WIDTH-1:0] rx_used_qwords,
  output logic [USED_QWORDS_WIDTH-1:0] rx_free_qwords,
  output logic                         irq_req,
  input  logic                         irq_ack,
  output logic                         db_err
);

  localparam int W = USED_QWORDS_WIDTH;

  localparam logic [7:0] ADDR_RPTR      = 8'h00;
  localparam logic [7:0] ADDR_CTRL      = 8'h01;
  localparam logic [7:0] ADDR_THRESH    = 8'h02;
  localparam logic [7:0] ADDR_HOLDOFF   = 8'h03;
  localparam logic [7:0] ADDR_STATUS    = 8'h04;
  localparam logic [7:0] ADDR_USED      = 8'h05;
  localparam logic [7:0] ADDR_IRQ_COUNT = 8'h06;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_REQ      = 2'd2,
    ST_HOLDOFF  = 2'd3
  } state_t;

  state_t                   state_q;
  state_t                   state_d;

  logic [W-1:0]             rptr_q;
  logic [W-1:0]             used_q;
  logic [W-1:0]             free_q;
  logic                     err_q;
  logic                     arm_q;
  logic                     oneshot_q;
  logic [W-1:0]             thresh_q;
  logic [HOLDOFF_WIDTH-1:0] holdoff_q;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt_q;
  logic [31:0]              irq_count_q;

  logic                     wr_rptr;
  logic                     wr_ctrl;
  logic                     wr_thresh;
  logic                     wr_holdoff;
  logic                     wr_status;
  logic [W-1:0]             new_rptr;
  logic [W-1:0]             adv;
  logic [W-1:0]             avail;
  logic                     overrun;
  logic                     ack_taken;
  logic [W-1:0]             thresh_eff;
  logic                     at_thresh;
  logic                     hold_done;
  logic                     unused_wrdata;

  // ---------------------------------------------------------------- decode
  assign wr_rptr    = db_wrena && (db_addr == ADDR_RPTR);
  assign wr_ctrl    = db_wrena && (db_addr == ADDR_CTRL);
  assign wr_thresh  = db_wrena && (db_addr == ADDR_THRESH);
  assign wr_holdoff = db_wrena && (db_addr == ADDR_HOLDOFF);
  assign wr_status  = db_wrena && (db_addr == ADDR_STATUS);

  assign unused_wrdata = ^db_wrdata;

  // A host write may consume at most what the DMA has produced so far.
  assign new_rptr = db_wrdata[W-1:0];
  assign adv      = new_rptr - rptr_q;
  assign avail    = rx_ring_wptr - rptr_q;
  assign overrun  = wr_rptr && (adv > avail);

  assign ack_taken  = (state_q == ST_REQ) && irq_ack;
  assign thresh_eff = (thresh_q == '0) ? W'(1) : thresh_q;
  assign at_thresh  = (used_q >= thresh_eff);
  assign hold_done  = (hold_cnt_q == '0);

  // ---------------------------------------------------------------- pointers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rptr_q <= '0;
      used_q <= '0;
      free_q <= '1;
    end else begin
      if (wr_rptr && !overrun) begin
        rptr_q <= new_rptr;
      end
      used_q <= rx_ring_wptr - rptr_q;
      free_q <= ~(rx_ring_wptr - rptr_q);
    end
  end

  // A fresh overrun wins over a same-cycle write-1-clear.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (overrun) begin
      err_q <= 1'b1;
    end else if (wr_status && db_wrdata[0]) begin
      err_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- config regs
  always_ff @(posedge clk_in) begin
    if (reset) begin
      arm_q     <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        arm_q     <= db_wrdata[0];
        oneshot_q <= db_wrdata[1];
      end
      if (ack_taken && oneshot_q) begin
        arm_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      thresh_q  <= W'(DEF_THRESH);
      holdoff_q <= HOLDOFF_WIDTH'(DEF_HOLDOFF);
    end else begin
      if (wr_thresh) begin
        thresh_q <= db_wrdata[W-1:0];
      end
      if (wr_holdoff) begin
        holdoff_q <= db_wrdata[HOLDOFF_WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- holdoff timer
  always_ff @(posedge clk_in) begin
    if (reset) begin
      hold_cnt_q <= '0;
    end else if (ack_taken) begin
      hold_cnt_q <= holdoff_q;
    end else if ((state_q == ST_HOLDOFF) && !hold_done) begin
      hold_cnt_q <= hold_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      irq_count_q <= '0;
    end else if (ack_taken) begin
      irq_count_q <= irq_count_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ST_DISARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISARMED: begin
        if (arm_q) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm_q)         state_d = ST_DISARMED;
        else if (at_thresh) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (irq_ack) state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (hold_done) state_d = arm_q ? ST_ARMED : ST_DISARMED;
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  always_comb begin
    irq_req = 1'b0;
    if (state_q == ST_REQ) begin
      irq_req = 1'b1;
    end
  end

  // ---------------------------------------------------------------- readback
  always_ff @(posedge clk_in) begin
    if (reset) begin
      db_rddata <= '0;
    end else begin
      case (db_addr)
        ADDR_RPTR:      db_rddata <= 32'(rptr_q);
        ADDR_CTRL:      db_rddata <= {30'd0, oneshot_q, arm_q};
        ADDR_THRESH:    db_rddata <= 32'(thresh_q);
        ADDR_HOLDOFF:   db_rddata <= 32'(holdoff_q);
        ADDR_STATUS:    db_rddata <= {22'd0, state_q, 7'd0, err_q};
        ADDR_USED:      db_rddata <= 32'(used_q);
        ADDR_IRQ_COUNT: db_rddata <= irq_count_q;
        default:        db_rddata <= '0;
      endcase
    end
  end

  assign rx_ring_rptr   = rptr_q;
  assign rx_used_qwords = used_q;
  assign rx_free_qwords = free_q;
  assign db_err         = err_q;

endmodule

// File: tb/tb_sonic_irq_doorbell.sv
// Directed bench for sonic_irq_doorbell: register map, threshold/holdoff moderation,
// pointer wrap and overrun, reset mid-handshake, disarm while requesting.
module tb_sonic_irq_doorbell;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        db_wrena;
  logic [7:0]  db_addr;
  logic [31:0] db_wrdata;
  logic [31:0] db_rddata;
  logic [15:0] rx_ring_wptr;
  logic [15:0] rx_ring_rptr;
  logic [15:0] rx_used_qwords;
  logic [15:0] rx_free_qwords;
  logic        irq_req;
  logic        irq_ack;
  logic        db_err;

  int checks = 0;
  int errors = 0;

  sonic_irq_doorbell dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .db_wrena       (db_wrena),
    .db_addr        (db_addr),
    .db_wrdata      (db_wrdata),
    .db_rddata      (db_rddata),
    .rx_ring_wptr   (rx_ring_wptr),
    .rx_ring_rptr   (rx_ring_rptr),
    .rx_used_qwords (rx_used_qwords),
    .rx_free_qwords (rx_free_qwords),
    .irq_req        (irq_req),
    .irq_ack        (irq_ack),
    .db_err         (db_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    db_wrena  = 1'b1;
    db_addr   = a;
    db_wrdata = d;
    tick();
    db_wrena  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    db_addr = a;
    tick();
    d = db_rddata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Returns cycles waited, or -1 if irq_req never rose within the budget.
  task automatic wait_irq(input int budget, output int n);
    n = 0;
    while (!irq_req && n < budget) begin
      tick();
      n++;
    end
    if (!irq_req) n = -1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_rd [7];
    exp_rd = '{32'd0, 32'd0, 32'd1, 32'd256, 32'd0, 32'd0, 32'd0};
    rx_ring_wptr = 16'h0000;
    do_reset();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_irq_req got %0b exp 0", irq_req); end
    checks++; if (rx_free_qwords !== 16'hFFFF) begin errors++; $display("FAIL reset_free got %h exp ffff", rx_free_qwords); end
    checks++; if (rx_used_qwords !== 16'h0000) begin errors++; $display("FAIL reset_used got %h exp 0000", rx_used_qwords); end
    checks++; if (db_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", db_err); end
    for (int i = 0; i < 7; i++) begin
      rd(8'(i), d);
      checks++;
      if (d !== exp_rd[i]) begin errors++; $display("FAIL reset_read[%0d] got %h exp %h", i, d, exp_rd[i]); end
    end
  endtask

  task automatic test_threshold();
    logic [31:0] d;
    do_reset();
    wr(8'h02, 32'd4);
    wr(8'h01, 32'd1);
    tick();
    for (int v = 0; v < 4; v++) begin
      rx_ring_wptr = 16'(v);
      tick();
      tick();
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL thresh_below wptr=%0d got %0b exp 0", v, irq_req); end
    end
    rx_ring_wptr = 16'd4;
    tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL thresh_early got %0b exp 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL thresh_rise got %0b exp 1", irq_req); end
    repeat (3) tick();
    checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL thresh_hold got %0b exp 1", irq_req); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL thresh_drop got %0b exp 0", irq_req); end
    rd(8'h06, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL thresh_count got %0d exp 1", d); end
  endtask

  task automatic test_holdoff();
    logic [31:0] d;
    int n;
    int m;
    logic seen;
    do_reset();
    wr(8'h03, 32'd10);
    rx_ring_wptr = 16'd100;
    tick();
    wr(8'h01, 32'd1);
    wait_irq(10, n);
    checks++; if (n < 0) begin errors++; $display("FAIL holdoff_first_req timeout"); end
    for (int k = 0; k < 2; k++) begin
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      m = 0;
      while (!irq_req && m < 40) begin
        tick();
        m++;
      end
      checks++; if (m != 12) begin errors++; $display("FAIL holdoff_gap[%0d] got %0d exp 12", k, m); end
    end
    rd(8'h06, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL holdoff_count got %0d exp 2", d); end

    // Oneshot; the CTRL write landing with the ack must not re-arm.
    do_reset();
    wr(8'h03, 32'd10);
    wr(8'h01, 32'd3);
    wait_irq(10, n);
    checks++; if (n < 0) begin errors++; $display("FAIL oneshot_req timeout"); end
    db_wrena  = 1'b1;
    db_addr   = 8'h01;
    db_wrdata = 32'd3;
    irq_ack   = 1'b1;
    tick();
    db_wrena  = 1'b0;
    irq_ack   = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (irq_req) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL oneshot_second_req got 1 exp 0"); end
    rd(8'h04, d);
    checks++; if (d[9:8] !== 2'd0) begin errors++; $display("FAIL oneshot_state got %0d exp 0", d[9:8]); end
    rd(8'h01, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL oneshot_ctrl got %h exp 2", d); end
    rd(8'h06, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL oneshot_count got %0d exp 1", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    do_reset();
    rx_ring_wptr = 16'hFFF0;
    tick();
    wr(8'h00, 32'h0000_FFF0);
    checks++; if (rx_ring_rptr !== 16'hFFF0 || db_err !== 1'b0) begin errors++; $display("FAIL wrap_setup rptr %h err %0b exp fff0 0", rx_ring_rptr, db_err); end
    rx_ring_wptr = 16'h0010;
    tick();
    tick();
    checks++; if (rx_used_qwords !== 16'h0020) begin errors++; $display("FAIL wrap_used got %h exp 0020", rx_used_qwords); end
    checks++; if (rx_free_qwords !== 16'hFFDF) begin errors++; $display("FAIL wrap_free got %h exp ffdf", rx_free_qwords); end
    wr(8'h00, 32'h0000_0010);
    checks++; if (rx_ring_rptr !== 16'h0010 || db_err !== 1'b0) begin errors++; $display("FAIL wrap_exact rptr %h err %0b exp 0010 0", rx_ring_rptr, db_err); end
    tick();
    checks++; if (rx_used_qwords !== 16'h0000) begin errors++; $display("FAIL wrap_empty got %h exp 0000", rx_used_qwords); end
    wr(8'h00, 32'h0000_0011);
    checks++; if (rx_ring_rptr !== 16'h0010) begin errors++; $display("FAIL overrun_rptr got %h exp 0010", rx_ring_rptr); end
    checks++; if (db_err !== 1'b1) begin errors++; $display("FAIL overrun_err got %0b exp 1", db_err); end
    rd(8'h04, d);
    checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL overrun_status got %0b exp 1", d[0]); end
    wr(8'h04, 32'd1);
    checks++; if (db_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", db_err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int n;
    do_reset();
    rx_ring_wptr = 16'd50;
    wr(8'h01, 32'd1);
    wait_irq(10, n);
    checks++; if (n < 0) begin errors++; $display("FAIL rstmid_req timeout"); end
    reset = 1'b1;
    tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rstmid_drop got %0b exp 0", irq_req); end
    reset   = 1'b0;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    rd(8'h06, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", d); end
    rd(8'h04, d);
    checks++; if (d[9:8] !== 2'd0) begin errors++; $display("FAIL rstmid_state got %0d exp 0", d[9:8]); end
  endtask

  task automatic test_disarm_in_req();
    logic [31:0] d;
    int n;
    do_reset();
    wr(8'h03, 32'd3);
    wr(8'h01, 32'd1);
    wait_irq(10, n);
    checks++; if (n < 0) begin errors++; $display("FAIL disarm_req timeout"); end
    wr(8'h01, 32'd0);
    tick();
    tick();
    checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL disarm_hold got %0b exp 1", irq_req); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL disarm_drop got %0b exp 0", irq_req); end
    rd(8'h04, d);
    checks++; if (d[9:8] !== 2'd3) begin errors++; $display("FAIL disarm_holdoff_state got %0d exp 3", d[9:8]); end
    repeat (6) tick();
    rd(8'h04, d);
    checks++; if (d[9:8] !== 2'd0) begin errors++; $display("FAIL disarm_final_state got %0d exp 0", d[9:8]); end
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL disarm_no_rereq got %0b exp 0", irq_req); end
  endtask

  initial begin
    reset        = 1'b1;
    db_wrena     = 1'b0;
    db_addr      = 8'h00;
    db_wrdata    = 32'd0;
    rx_ring_wptr = 16'd0;
    irq_ack      = 1'b0;
    test_reset();
    test_threshold();
    test_holdoff();
    test_wrap();
    test_reset_mid();
    test_disarm_in_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
